// File: rtl/save_ram_streamer.sv
// Save-RAM streamer: unloads byte-wide save RAM into packed 32-bit words and
// loads 32-bit words back into save RAM, one byte per cycle.
module save_ram_streamer #(
    parameter int ADDR_W     = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_unload,
    input  logic              start_load,
    input  logic [ADDR_W:0]   save_size,
    input  logic              endian_little,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_wren,
    input  logic [7:0]        ram_rdata,
    output logic [31:0]       out_word,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [31:0]       in_word,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              busy,
    output logic              done
);

    // state      | meaning
    // IDLE       | waiting for a start request
    // UNLOAD     | issuing RAM reads and packing bytes into words
    // DRAIN      | all words pushed, waiting for the FIFO to empty
    // LOAD_WAIT  | waiting for the next input word
    // LOAD_WRITE | writing the latched word's bytes into RAM
    // FINISH     | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE, S_UNLOAD, S_DRAIN, S_LOAD_WAIT, S_LOAD_WRITE, S_FINISH
    } state_t;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   cap_idx_q, cap_idx_d;
    logic              little_q, little_d;
    logic              rd_pend_q, rd_pend_d;
    logic [31:0]       pack_q, pack_d;
    logic [31:0]       in_q, in_d;

    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [ADDR_W:0]   idx_inc, cap_inc, len_clamp;
    logic [1:0]        cap_pos, ld_pos;
    logic [31:0]       merged;
    logic [7:0]        ld_byte;
    logic [CNT_W:0]    cnt_ext;
    logic              cap_last, push, pop, issue;

    assign idx_inc   = idx_q + (ADDR_W+1)'(1);
    assign cap_inc   = cap_idx_q + (ADDR_W+1)'(1);
    assign len_clamp = (save_size > MAX_LEN) ? MAX_LEN : save_size;

    assign cap_pos  = little_q ? cap_idx_q[1:0] : ~cap_idx_q[1:0];
    assign merged   = pack_q | ({24'b0, ram_rdata} << {cap_pos, 3'b000});
    assign cap_last = (cap_inc == len_q);
    assign push     = rd_pend_q && ((cap_idx_q[1:0] == 2'd3) || cap_last);
    assign pop      = (cnt_q != '0) && out_ready;

    // Count a push landing this cycle so a freshly issued final byte can never
    // produce a word while the FIFO is already full.
    assign cnt_ext = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(push);
    assign issue   = (state_q == S_UNLOAD) && (idx_q != len_q)
                     && (cnt_ext < (CNT_W+1)'(FIFO_DEPTH));

    assign ld_pos  = little_q ? idx_q[1:0] : ~idx_q[1:0];
    assign ld_byte = 8'(in_q >> {ld_pos, 3'b000});

    assign out_word  = fifo_mem[rd_ptr_q];
    assign out_valid = (cnt_q != '0);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        little_d  = little_q;
        in_d      = in_q;
        rd_pend_d = issue;
        cap_idx_d = issue ? idx_q : cap_idx_q;
        pack_d    = push ? 32'd0 : (rd_pend_q ? merged : pack_q);
        ram_addr  = '0;
        ram_wdata = 8'd0;
        ram_wren  = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start_unload || start_load) begin
                    len_d    = len_clamp;
                    little_d = endian_little;
                    idx_d    = '0;
                    pack_d   = 32'd0;
                    if (len_clamp == '0)
                        state_d = S_FINISH;
                    else if (start_unload)
                        state_d = S_UNLOAD;
                    else
                        state_d = S_LOAD_WAIT;
                end
            end
            S_UNLOAD: begin
                if (issue) begin
                    ram_addr = idx_q[ADDR_W-1:0];
                    idx_d    = idx_inc;
                end
                if (push && cap_last)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (cnt_q == '0)
                    state_d = S_FINISH;
            end
            S_LOAD_WAIT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    in_d    = in_word;
                    state_d = S_LOAD_WRITE;
                end
            end
            S_LOAD_WRITE: begin
                ram_wren  = 1'b1;
                ram_addr  = idx_q[ADDR_W-1:0];
                ram_wdata = ld_byte;
                idx_d     = idx_inc;
                if (idx_inc == len_q)
                    state_d = S_FINISH;
                else if (idx_q[1:0] == 2'd3)
                    state_d = S_LOAD_WAIT;
            end
            S_FINISH: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            cap_idx_q <= '0;
            little_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            pack_q    <= 32'd0;
            in_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            cap_idx_q <= cap_idx_d;
            little_q  <= little_d;
            rd_pend_q <= rd_pend_d;
            pack_q    <= pack_d;
            in_q      <= in_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                fifo_mem[i] <= 32'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= merged;
                wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_save_ram_streamer.sv
// Directed bench for save_ram_streamer: behavioural save RAM, stream monitor
// and hand-computed expected words/bytes.
module tb_save_ram_streamer;
    localparam int ADDR_W = 11;
    localparam int FIFO_DEPTH = 4;

    logic              clk, reset, start_unload, start_load, endian_little;
    logic [ADDR_W:0]   save_size;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata, ram_rdata;
    logic              ram_wren, out_valid, out_ready, in_valid, in_ready, busy, done;
    logic [31:0]       out_word, in_word;

    save_ram_streamer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset(reset), .start_unload(start_unload), .start_load(start_load),
        .save_size(save_size), .endian_little(endian_little), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_rdata(ram_rdata),
        .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
        .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Save RAM with a backdoor write port for preloading
    logic [7:0]        mem [0:(1<<ADDR_W)-1];
    logic              bd_we;
    logic [ADDR_W-1:0] bd_addr;
    logic [7:0]        bd_data;
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    logic [31:0] pops [$];
    int done_cnt = 0;
    int wren_cnt = 0;
    always @(negedge clk) begin
        if (out_valid && out_ready) pops.push_back(out_word);
        if (done) done_cnt++;
        if (ram_wren) wren_cnt++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ram"}, {11'd0, ram_wren, ram_wdata, ram_addr}, 32'd0);
        check({tag, "_word"}, out_word, 32'd0);
        check({tag, "_flags"}, {28'd0, out_valid, in_ready, busy, done}, 32'd0);
    endtask

    task automatic poke(input int a, input logic [7:0] d);
        bd_addr = ADDR_W'(a);
        bd_data = d;
        bd_we = 1'b1;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic start(input bit unl, input bit ld, input int size, input bit le);
        save_size = (ADDR_W+1)'(size);
        endian_little = le;
        start_unload = unl;
        start_load = ld;
        @(posedge clk); #1;
        start_unload = 1'b0;
        start_load = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base, input int budget);
        int n = 0;
        while (done_cnt == base && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 32'(done_cnt != base), 32'd1);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic send_word(input string tag, input logic [31:0] w);
        bit acc = 1'b0;
        in_word = w;
        in_valid = 1'b1;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check(tag, 32'(acc), 32'd1);
    endtask

    int pb, db, wb;
    logic [31:0] exp_w;

    initial begin
        reset = 1'b1;
        start_unload = 0; start_load = 0; endian_little = 1; save_size = '0;
        out_ready = 0; in_word = 0; in_valid = 0;
        bd_we = 0; bd_addr = '0; bd_data = 0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Unload little-endian, 8 bytes
        for (int i = 0; i < 8; i++) poke(i, 8'(i));
        out_ready = 1;
        pb = pops.size(); db = done_cnt; wb = wren_cnt;
        start(1, 0, 8, 1);
        wait_done("ul_le_done", db, 100);
        check("ul_le_npop", pops.size() - pb, 2);
        if (pops.size() >= pb + 2) begin
            check("ul_le_w0", pops[pb], 32'h03020100);
            check("ul_le_w1", pops[pb+1], 32'h07060504);
        end
        check("ul_le_ndone", done_cnt - db, 1);
        check("ul_le_nwren", wren_cnt - wb, 0);

        // Unload big-endian, 5 bytes with zero padding
        for (int i = 0; i < 5; i++) poke(i, 8'(8'hA0 + i));
        pb = pops.size(); db = done_cnt;
        start(1, 0, 5, 0);
        wait_done("ul_be_done", db, 100);
        check("ul_be_npop", pops.size() - pb, 2);
        if (pops.size() >= pb + 2) begin
            check("ul_be_w0", pops[pb], 32'hA0A1A2A3);
            check("ul_be_w1", pops[pb+1], 32'hA4000000);
        end

        // Unload 64 bytes with backpressure until the FIFO fills
        for (int i = 0; i < 64; i++) poke(i, 8'(i * 7 + 3));
        out_ready = 0;
        pb = pops.size(); db = done_cnt;
        start(1, 0, 64, 1);
        repeat (30) begin @(posedge clk); #1; end
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_count", 32'(dut.cnt_q), FIFO_DEPTH);
        check("stall_npop", pops.size() - pb, 0);
        out_ready = 1;
        wait_done("stall_done", db, 400);
        check("stall_total", pops.size() - pb, 16);
        if (pops.size() >= pb + 16) begin
            for (int k = 0; k < 16; k++) begin
                exp_w = {8'((4*k+3)*7+3), 8'((4*k+2)*7+3), 8'((4*k+1)*7+3), 8'((4*k)*7+3)};
                check($sformatf("stall_w%0d", k), pops[pb+k], exp_w);
            end
        end

        // Load little-endian, 6 bytes
        for (int i = 0; i < 8; i++) poke(i, 8'hEE);
        db = done_cnt; wb = wren_cnt;
        start(0, 1, 6, 1);
        send_word("ld_acc0", 32'h44332211);
        send_word("ld_acc1", 32'h88776655);
        wait_done("ld_done", db, 100);
        check("ld_bytes03", {mem[3], mem[2], mem[1], mem[0]}, 32'h44332211);
        check("ld_bytes47", {mem[7], mem[6], mem[5], mem[4]}, 32'hEEEE6655);
        check("ld_nwren", wren_cnt - wb, 6);
        check("ld_ndone", done_cnt - db, 1);

        // Both starts together, zero length
        pb = pops.size(); db = done_cnt; wb = wren_cnt;
        start(1, 1, 0, 1);
        @(negedge clk);
        check("zero_done", {30'd0, done, busy}, 32'h2);
        @(negedge clk);
        check("zero_done_end", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("zero_npop", pops.size() - pb, 0);
        check("zero_nwren", wren_cnt - wb, 0);
        check("zero_ndone", done_cnt - db, 1);
        check("zero_valid", 32'(out_valid), 32'd0);

        // Reset mid-load after two bytes
        for (int i = 0; i < 8; i++) poke(i, 8'h55);
        db = done_cnt; wb = wren_cnt;
        start(0, 1, 8, 1);
        send_word("rl_acc", 32'hDDCCBBAA);
        for (int n = 0; n < 20 && (wren_cnt - wb) < 2; n++) begin
            @(posedge clk); #1;
        end
        check("rl_two_writes", wren_cnt - wb, 2);
        reset = 1'b1;
        #1;
        check_zero_outputs("rl_reset");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("rl_ram", {mem[3], mem[2], mem[1], mem[0]}, 32'h5555BBAA);
        check("rl_nwren", wren_cnt - wb, 2);
        check("rl_ndone", done_cnt - db, 0);

        pb = pops.size(); db = done_cnt;
        out_ready = 1;
        start(1, 0, 4, 1);
        wait_done("rl_ul_done", db, 100);
        check("rl_ul_npop", pops.size() - pb, 1);
        if (pops.size() >= pb + 1)
            check("rl_ul_w0", pops[pb], 32'h5555BBAA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/save_ram_streamer.md
Name: save_ram_streamer

Overview:
- Moves battery-backed save RAM contents between the save-RAM dual-port memory (byte-wide, port B side) and a 32-bit word stream toward the APF bridge save path.
- Unload: reads save_size bytes sequentially and packs them into 32-bit words in a small output FIFO.
- Load: accepts 32-bit words, unpacks them and writes the bytes into save RAM.
- Sits between the save-RAM dpram and the bridge-side save-file handler. It runs entirely in the core clock domain; any CDC to the 74 MHz bridge clock is handled outside this block.

Parameters:
- ADDR_W, 11: save RAM byte address width; capacity is 2^ADDR_W bytes.
- FIFO_DEPTH, 4: number of 32-bit words in the unload FIFO; must be a power of two and at least 2.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- start_unload  in  1  single-cycle request to begin an unload.
- start_load  in  1  single-cycle request to begin a load.
- save_size  in  ADDR_W+1  transfer length in bytes; sampled on start.
- endian_little  in  1  1 = byte0 in [7:0]; 0 = byte0 in [31:24]; sampled on start.
- ram_addr  out  ADDR_W  save RAM byte address.
- ram_wdata  out  8  save RAM write data.
- ram_wren  out  1  save RAM write strobe.
- ram_rdata  in  8  save RAM read data; valid one cycle after ram_addr.
- out_word  out  32  unload stream data; this is the FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer pop; a pop occurs when out_valid & out_ready.
- in_word  in  32  load stream data.
- in_valid  in  1  load word offered.
- in_ready  out  1  block accepts in_word; acceptance occurs when in_valid & in_ready.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values:
  - All outputs are 0: ram_addr, ram_wdata, ram_wren, out_word, out_valid, in_ready, busy, done.
  - FIFO is flushed; state is IDLE.
  - Assertion mid-transfer aborts immediately; there is no done pulse and no further RAM writes.
- States: IDLE, UNLOAD, DRAIN, LOAD_WAIT, LOAD_WRITE, FINISH.
- IDLE:
  - start_unload goes to UNLOAD; start_load goes to LOAD_WAIT.
  - If both are asserted, unload wins.
  - Starts are ignored in every other state.
  - On start, the block latches len = min(save_size, 2^ADDR_W) and endian_little, clears the byte index, and asserts busy.
  - If len == 0, the block goes straight to FINISH (done pulses on the next cycle).
- UNLOAD:
  - Issues ram_addr = index only while fifo_count < FIFO_DEPTH; otherwise it stalls.
  - At most one read is in flight.
  - Reads are pipelined: a new address may issue in the same cycle that the previous byte is captured, giving 1 byte/cycle throughput when not stalled.
  - The captured byte goes into lane (index mod 4), placed according to the latched endianness.
  - A word is pushed after its 4th byte, or after the final byte with unfilled lanes zero-padded.
  - After the last push, the block goes to DRAIN.
  - Example: len = 6 pushes 2 words; lanes 2 and 3 of the second word are 0.
- FIFO:
  - Push and pop may occur in the same cycle; count is then unchanged.
  - out_word is stable while out_valid & !out_ready.
  - A push never happens when the FIFO is full; this is guaranteed by the issue rule above.
- DRAIN: waits for the FIFO to become empty, then goes to FINISH.
- LOAD_WAIT:
  - in_ready = 1.
  - On acceptance, the word is latched and the block goes to LOAD_WRITE with in_ready deasserted the next cycle.
- LOAD_WRITE:
  - Writes one byte per cycle: ram_wren = 1, ram_addr = index, ram_wdata = the appropriate lane.
  - Covers up to 4 bytes, or fewer if len is reached.
  - When len is reached, the block goes to FINISH; any remaining lanes are discarded.
  - Otherwise, after 4 bytes it returns to LOAD_WAIT.
- FINISH: done = 1 for exactly one cycle, busy drops in that same cycle, and the block returns to IDLE.
- busy is 1 in all states except IDLE and FINISH.
- Widths:
  - index is ADDR_W+1 bits, so len = 2^ADDR_W terminates without wrapping.
  - ram_addr is index[ADDR_W-1:0].
  - save_size values above 2^ADDR_W are clamped.
- ram_wren is never asserted outside LOAD_WRITE.

Test Plan:
- Unload, little-endian, len = 8, RAM bytes 0x00..0x07, out_ready held 1:
  - Words 0x03020100 then 0x07060504.
  - done pulses once; no write strobes occur.
- Unload, big-endian, len = 5, RAM bytes 0xA0..0xA4:
  - Words 0xA0A1A2A3 then 0xA4000000.
- Unload 64 bytes with out_ready = 0 until the FIFO fills:
  - Reads stall with out_valid = 1 and count = FIFO_DEPTH.
  - No data is lost after out_ready is released.
  - The 16 words match RAM in order.
- Load, little-endian, len = 6, words 0x44332211 and 0x88776655:
  - RAM[0..5] = 11 22 33 44 55 66; RAM[6..7] are untouched.
  - Exactly 6 ram_wren cycles; done pulses once.
- start_unload and start_load asserted together with len = 0:
  - done pulses one cycle later with no RAM activity and no FIFO push.
- reset asserted mid-load after 2 bytes written:
  - All outputs go to 0 immediately; no further writes and no done pulse.
  - A subsequent unload works normally.
